// File: rtl/sram_pkg.sv
// Shared ZBT SRAM definitions: bus widths, chip-select encoding, byte lanes and the command record
// that travels down the controller/responder pipelines.
package sram_pkg;

  localparam int SRAM_DATA_W = 18;
  localparam int SRAM_ADDR_W = 20;

  // {CE3_n, CE2, CE1_n} value that selects the device
  localparam logic [2:0] CHIP_SEL = 3'b010;

  localparam int NUM_LANES = 2;
  localparam int LANE_W    = SRAM_DATA_W / NUM_LANES;

  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
  } sram_cmd_t;

endpackage

// File: rtl/sram_byte_mem.sv
// Two-lane byte-write RAM with one write port and one registered read port (block-RAM style).
// The read register has an asynchronous clear so it can serve directly as the SRAM output register.
module sram_byte_mem
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [NUM_LANES-1:0]  be,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int LW = DATA_WIDTH / NUM_LANES;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (be[l]) mem[waddr][l*LW +: LW] <= wdata[l*LW +: LW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/zbt_sram_responder.sv
// Pipelined ZBT SSRAM responder: commands sampled at enabled edge E complete their data phase at E+2.
// Owns the command pipeline, asynchronous OE gating, saturating statistics and the sticky error flag.
module zbt_sram_responder
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 20,
  parameter int DEPTH_LOG2 = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data_in,
  output logic [DATA_WIDTH-1:0] sram_data_out,
  output logic                  sram_data_oe,
  input  logic [1:0]            sram_bw,
  input  logic                  sram_advload,
  input  logic                  sram_write_enable,
  input  logic [2:0]            sram_chip_enable,
  input  logic                  sram_oe,
  input  logic                  sram_clk_enable,
  output logic [CNT_WIDTH-1:0]  read_count,
  output logic [CNT_WIDTH-1:0]  write_count,
  output logic                  protocol_err
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic      en;
  logic      sel;
  sram_cmd_t cmd_p0, cmd_p1, cmd_p2;
  logic      rd_go, wr_go, err_now;
  logic      rd_phase;
  logic      unused_addr_hi;

  assign en  = ~sram_clk_enable;
  assign sel = (sram_chip_enable == CHIP_SEL);

  always_comb begin
    cmd_p0       = '0;
    cmd_p0.valid = sel & ~sram_advload;
    cmd_p0.we    = ~sram_write_enable;
    cmd_p0.addr  = SRAM_ADDR_W'(sram_addr);
  end

  assign rd_go   = cmd_p2.valid & ~cmd_p2.we;
  assign wr_go   = cmd_p2.valid &  cmd_p2.we;
  // Writing while the controller still has OE asserted means both sides drive the bus.
  assign err_now = (wr_go & ~sram_oe) | (sel & sram_advload);

  // Stage p0 -> p1 -> p2 command pipeline plus data-phase bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_p1.valid <= 1'b0;
      cmd_p2.valid <= 1'b0;
      rd_phase     <= 1'b0;
      read_count   <= '0;
      write_count  <= '0;
      protocol_err <= 1'b0;
    end else if (en) begin
      cmd_p1   <= cmd_p0;
      cmd_p2   <= cmd_p1;
      rd_phase <= rd_go;
      if (rd_go)   read_count   <= sat_inc(read_count);
      if (wr_go)   write_count  <= sat_inc(write_count);
      if (err_now) protocol_err <= 1'b1;
    end
  end

  // Stage p2 data phase: only one op sits here per cycle, so reads see prior commits without forwarding
  sram_byte_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (en & wr_go),
    .be    (~sram_bw),
    .waddr (cmd_p2.addr[DEPTH_LOG2-1:0]),
    .wdata (sram_data_in),
    .re    (en & rd_go),
    .raddr (cmd_p2.addr[DEPTH_LOG2-1:0]),
    .rdata (sram_data_out)
  );

  // Upper address bits alias onto the modelled depth
  assign unused_addr_hi = ^cmd_p2.addr[SRAM_ADDR_W-1:DEPTH_LOG2];

  assign sram_data_oe = rd_phase & ~sram_oe;

endmodule

// File: tb/tb_zbt_sram_responder.sv
// Scoreboard bench for zbt_sram_responder: a cycle model of the ZBT pipeline queues expected read
// data at each data phase and compares it when the responder presents it.
module tb_zbt_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] sram_addr;
  logic [17:0] sram_data_in;
  logic [17:0] sram_data_out;
  logic        sram_data_oe;
  logic [1:0]  sram_bw;
  logic        sram_advload;
  logic        sram_write_enable;
  logic [2:0]  sram_chip_enable;
  logic        sram_oe;
  logic        sram_clk_enable;
  logic [15:0] read_count;
  logic [15:0] write_count;
  logic        protocol_err;

  always #5 clk = ~clk;

  zbt_sram_responder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sram_addr         (sram_addr),
    .sram_data_in      (sram_data_in),
    .sram_data_out     (sram_data_out),
    .sram_data_oe      (sram_data_oe),
    .sram_bw           (sram_bw),
    .sram_advload      (sram_advload),
    .sram_write_enable (sram_write_enable),
    .sram_chip_enable  (sram_chip_enable),
    .sram_oe           (sram_oe),
    .sram_clk_enable   (sram_clk_enable),
    .read_count        (read_count),
    .write_count       (write_count),
    .protocol_err      (protocol_err)
  );

  typedef struct {
    bit          v;
    bit          we;
    logic [9:0]  a;
    logic [17:0] d;
    logic [1:0]  bw;
  } op_t;

  op_t         p1, p2;
  logic [17:0] mmem [1024];
  logic [17:0] exp_q [$];
  int          exp_rc, exp_wc;
  bit          exp_err, exp_rdph;
  logic [17:0] exp_dout;
  int          n_vec, n_err;
  bit          oe_force;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive a command, the data-phase inputs for whatever sits in stage 2, then check.
  task automatic step(input int kind, input logic [19:0] addr, input logic [17:0] d,
                      input logic [1:0] bw, input logic [2:0] ce, input bit adv, input bit stall);
    op_t         c;
    bit          did_rd;
    logic [17:0] e;
    did_rd            = 1'b0;
    sram_addr         = addr;
    sram_chip_enable  = ce;
    sram_advload      = adv;
    sram_write_enable = (kind == 2) ? 1'b0 : 1'b1;
    sram_data_in      = p2.d;
    sram_bw           = p2.bw;
    sram_clk_enable   = stall;
    sram_oe           = oe_force ? 1'b0 : ((p2.v && p2.we) ? 1'b1 : 1'b0);
    c.v  = (ce == 3'b010) && !adv;
    c.we = (kind == 2);
    c.a  = addr[9:0];
    c.d  = d;
    c.bw = bw;
    if (!stall) begin
      if (p2.v && p2.we) begin
        if (!p2.bw[0]) mmem[p2.a][8:0]  = p2.d[8:0];
        if (!p2.bw[1]) mmem[p2.a][17:9] = p2.d[17:9];
        if (exp_wc < 65535) exp_wc++;
        if (sram_oe == 1'b0) exp_err = 1'b1;
      end
      if (p2.v && !p2.we) begin
        exp_q.push_back(mmem[p2.a]);
        did_rd = 1'b1;
        if (exp_rc < 65535) exp_rc++;
      end
      exp_rdph = p2.v && !p2.we;
      if (ce == 3'b010 && adv) exp_err = 1'b1;
      p2 = p1;
      p1 = c;
    end
    @(posedge clk);
    #1;
    if (did_rd) begin
      e        = exp_q.pop_front();
      exp_dout = e;
      chk("rd_data", {14'd0, sram_data_out}, {14'd0, e});
    end else begin
      chk("dout_hold", {14'd0, sram_data_out}, {14'd0, exp_dout});
    end
    chk("data_oe", {31'd0, sram_data_oe}, {31'd0, exp_rdph & ~sram_oe});
    chk("read_count", {16'd0, read_count}, exp_rc);
    chk("write_count", {16'd0, write_count}, exp_wc);
    chk("protocol_err", {31'd0, protocol_err}, {31'd0, exp_err});
  endtask

  task automatic nop();
    step(0, 20'h0, 18'h0, 2'b11, 3'b000, 1'b0, 1'b0);
  endtask
  task automatic rd(input logic [19:0] a);
    step(1, a, 18'h0, 2'b11, 3'b010, 1'b0, 1'b0);
  endtask
  task automatic wr(input logic [19:0] a, input logic [17:0] d, input logic [1:0] bw);
    step(2, a, d, bw, 3'b010, 1'b0, 1'b0);
  endtask
  task automatic stl();
    step(0, 20'h0, 18'h0, 2'b11, 3'b000, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    sram_addr = '0; sram_data_in = '0; sram_bw = 2'b11; sram_advload = 1'b0;
    sram_write_enable = 1'b1; sram_chip_enable = 3'b000; sram_oe = 1'b1; sram_clk_enable = 1'b0;
    rst_n = 1'b0;
    #1;
    p1.v = 1'b0; p2.v = 1'b0;
    exp_q.delete();
    exp_rc = 0; exp_wc = 0; exp_err = 1'b0; exp_rdph = 1'b0; exp_dout = '0;
    chk("rst_dout", {14'd0, sram_data_out}, 32'd0);
    chk("rst_oe", {31'd0, sram_data_oe}, 32'd0);
    chk("rst_rcnt", {16'd0, read_count}, 32'd0);
    chk("rst_wcnt", {16'd0, write_count}, 32'd0);
    chk("rst_err", {31'd0, protocol_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; oe_force = 1'b0;
    p1 = '{default: '0}; p2 = '{default: '0};
    p2.bw = 2'b11; p1.bw = 2'b11;
    do_reset();

    // basic write then read
    wr(20'h00010, 18'h2A5A5, 2'b00); nop(); rd(20'h00010); nop(); nop();

    // byte lanes: only lane 0 written
    wr(20'h00020, 18'h3FFFF, 2'b00); wr(20'h00020, 18'h00000, 2'b10); nop();
    rd(20'h00020); nop(); nop();

    // address aliasing above the modelled depth, plus a bw=11 write that changes nothing
    wr(20'h00430, 18'h1F0F0, 2'b00); wr(20'h00030, 18'h00000, 2'b11); nop();
    rd(20'hFFC30); nop(); nop();

    // back-to-back write/read with no turnaround
    wr(20'h5, 18'h11111, 2'b00); rd(20'h5); wr(20'h5, 18'h22222, 2'b00); rd(20'h5); nop(); nop();

    // stall: pipeline and data_out freeze while clk_enable is high
    wr(20'h7, 18'h12345, 2'b00); nop(); nop();
    rd(20'h7); stl(); stl(); stl(); nop(); nop();

    // deselected read does nothing
    step(1, 20'h7, 18'h0, 2'b11, 3'b000, 1'b0, 1'b0); nop(); nop();

    // asynchronous output enable
    wr(20'h7, 18'h0ABCD, 2'b00); nop(); rd(20'h7); nop(); nop();
    sram_oe = 1'b1; #1;
    chk("oe_async_off", {31'd0, sram_data_oe}, 32'd0);
    sram_oe = 1'b0; #1;
    chk("oe_async_on", {31'd0, sram_data_oe}, 32'd1);

    // bus contention sets the sticky error
    oe_force = 1'b1;
    wr(20'h9, 18'h00ABC, 2'b00); nop(); nop();
    oe_force = 1'b0;
    nop(); nop(); rd(20'h9); nop(); nop();

    // reset with a write in stage 2 drops it
    wr(20'h00010, 18'h15555, 2'b00); nop();
    do_reset();
    nop(); nop(); rd(20'h00010); nop(); nop();

    // advance/load: ignored when deselected, error when selected
    step(1, 20'h1, 18'h0, 2'b11, 3'b000, 1'b1, 1'b0); nop(); nop();
    step(1, 20'h1, 18'h0, 2'b11, 3'b010, 1'b1, 1'b0); nop(); nop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
